// File: rtl/timer_dev.sv
// Bus-mapped countdown timer: CTRL/PRESET/COUNT word registers and a level
// interrupt (IM & pend). One-shot or auto-reload with a LOAD/CNT/INT sequence.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;

  logic en, auto_rl, wr_ctrl, wr_pre, pend_set, pend_clr, hw_en_clr;

  assign en      = ctrl_q[0];
  assign auto_rl = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl = we && (addr == 2'd0);
  assign wr_pre  = we && (addr == 2'd1);
  assign irq     = ctrl_q[3] & pend_q;

  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout = {28'd0, ctrl_q};
      2'd1:    dout = 32'(preset_q);
      2'd2:    dout = 32'(count_q);
      default: dout = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    hw_en_clr = 1'b0;
    case (state_q)
      S_IDLE: if (en) state_d = S_LOAD;
      S_LOAD: begin
        if (!en) state_d = S_IDLE;
        else begin
          count_d = preset_q;
          if (preset_q != '0) state_d = S_CNT;
          else begin
            state_d  = S_INT;
            pend_set = 1'b1;
          end
        end
      end
      S_CNT: begin
        if (!en) state_d = S_IDLE;
        else if (count_q <= CNT_W'(1)) begin
          // terminal count: park at zero rather than wrapping
          count_d  = '0;
          state_d  = S_INT;
          pend_set = 1'b1;
        end else count_d = count_q - CNT_W'(1);
      end
      S_INT: begin
        if (!en) state_d = S_IDLE;
        else if (auto_rl) begin
          state_d  = S_LOAD;
          pend_clr = 1'b1;
        end else begin
          state_d   = S_IDLE;
          hw_en_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // CPU writes are applied last so they win over hardware EN-clear / pend-set.
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    pend_d   = pend_q;
    if (pend_set)  pend_d = 1'b1;
    if (pend_clr)  pend_d = 1'b0;
    if (hw_en_clr) ctrl_d[0] = 1'b0;
    if (wr_ctrl) begin
      ctrl_d = din[3:0];
      pend_d = 1'b0;
    end
    if (wr_pre) begin
      preset_d = din[CNT_W-1:0];
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: period-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  timer_dev #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din),
    .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: a run is a sequence of periods; pos 0 is the reload
  // tick, pos 1..len+1 walk down from len, the final position raises pend.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  bit          m_pend, m_act;
  longint      m_pos, m_len;
  bit          md_en, md_auto, md_set;

  always @(posedge clk) begin
    if (!reset) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_pend = 0; m_act = 0;
      m_pos = 0; m_len = 0;
    end else begin
      md_en   = m_ctrl[0];
      md_auto = (m_ctrl[2:1] == 2'b01);
      md_set  = 0;
      if (!m_act) begin
        if (md_en) begin m_act = 1; m_pos = 0; end
      end else if (!md_en) m_act = 0;
      else if (m_pos == 0) begin
        m_len = longint'(m_preset); m_count = m_preset; m_pos = 1;
        if (m_len == 0) md_set = 1;
      end else if (m_pos == m_len + 1) begin
        if (md_auto) begin m_pos = 0; m_pend = 0; end
        else begin m_act = 0; m_ctrl[0] = 1'b0; end
      end else begin
        m_pos++;
        m_count = 32'(m_len - (m_pos - 1));
        if (m_pos == m_len + 1) md_set = 1;
      end
      if (md_set) m_pend = 1;
      if (we && addr == 2'd0) begin m_ctrl = din[3:0]; m_pend = 0; end
      if (we && addr == 2'd1) begin m_preset = din; m_pend = 0; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] m_dout;
  always @(negedge clk) begin
    if (chk_on) begin
      case (addr)
        2'd0:    m_dout = {28'd0, m_ctrl};
        2'd1:    m_dout = m_preset;
        2'd2:    m_dout = m_count;
        default: m_dout = '0;
      endcase
      chk("model_irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_pend});
      chk("model_dout", dout, m_dout);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; din = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a; #1; v = dout;
  endtask

  task automatic rst();
    reset = 1'b0; we = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  logic [31:0] v;
  int ones, mx, first, second, r;

  initial begin
    tick(); tick();
    reset = 1'b1;
    chk_on = 1'b1;

    // reset after random traffic
    wr(2'd1, 32'd9); wr(2'd0, 32'hB);
    for (int i = 0; i < 4; i++) wr(2'($urandom_range(0, 3)), $urandom);
    tick(); tick();
    rst();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk("reset_dout", v, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // one-shot, PRESET=5
    rst();
    wr(2'd1, 32'd5); wr(2'd0, 32'h9);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      rd(2'd2, v);
      chk("oneshot_count", v, 32'(5 - i));
      chk("oneshot_model_count", m_count, 32'(5 - i));
      if (i < 5) chk("oneshot_irq_low", {31'd0, irq}, 32'd0);
    end
    chk("oneshot_irq_c7", {31'd0, irq}, 32'd1);
    tick();
    rd(2'd0, v);
    chk("oneshot_ctrl_en_clr", v, 32'h8);
    tick(); tick(); tick();
    chk("oneshot_irq_held", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h8);
    chk("oneshot_irq_cleared", {31'd0, irq}, 32'd0);

    // auto-reload, PRESET=3
    rst();
    wr(2'd1, 32'd3); wr(2'd0, 32'hB);
    ones = 0; mx = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rd(2'd2, v);
      if (int'(v) > mx) mx = int'(v);
      if (irq) ones++;
    end
    chk("reload_pulses", 32'(ones), 32'd4);
    chk("reload_max_count", 32'(mx), 32'd3);

    // masked interrupt
    rst();
    wr(2'd1, 32'd5); wr(2'd0, 32'h1);
    ones = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (irq) ones++; end
    wr(2'd0, 32'h8);
    for (int i = 0; i < 4; i++) begin tick(); if (irq) ones++; end
    chk("mask_irq_never", 32'(ones), 32'd0);

    // stop / restart
    rst();
    wr(2'd1, 32'd100); wr(2'd0, 32'h1);
    v = '0;
    for (int i = 0; i < 200 && v != 32'd60; i++) begin tick(); rd(2'd2, v); end
    chk("stop_reached_60", v, 32'd60);
    wr(2'd0, 32'h0);
    tick(); tick(); tick();
    rd(2'd2, v);
    chk("stop_frozen", {31'd0, (v == 32'd59 || v == 32'd60)}, 32'd1);
    wr(2'd0, 32'h1);
    tick(); tick();
    rd(2'd2, v);
    chk("restart_reload", v, 32'd100);

    // PRESET=0 fires after two cycles
    rst();
    wr(2'd0, 32'h0); wr(2'd0, 32'h9);
    tick();
    chk("zero_irq_c1", {31'd0, irq}, 32'd0);
    tick();
    chk("zero_irq_c2", {31'd0, irq}, 32'd1);

    // PRESET rewrite mid-count only changes the following period
    rst();
    wr(2'd1, 32'd3); wr(2'd0, 32'hB);
    first = 0; second = 0;
    for (int n = 0; n < 30; ) begin
      if (n == 2) begin we = 1'b1; addr = 2'd1; din = 32'd7; end
      else we = 1'b0;
      tick();
      n++;
      if (irq && first == 0) first = n;
      else if (irq && second == 0) second = n;
    end
    we = 1'b0;
    chk("preset_mid_first", 32'(first), 32'd5);
    chk("preset_mid_period", 32'(second - first), 32'd9);

    // randomized traffic, checked against the model every cycle
    rst();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 2) begin
        reset = 1'b0; we = 1'b0;
      end else begin
        reset = 1'b1;
        we = (r < 30);
        addr = 2'($urandom_range(0, 3));
        din = $urandom;
        if (addr == 2'd0) din[0] = ($urandom_range(0, 3) != 0);
        else if (addr == 2'd1 && $urandom_range(0, 7) != 0) din = $urandom_range(0, 12);
      end
      tick();
    end
    reset = 1'b1; we = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
